coin_collector: RTL
===================

# coin_collector

Sequential coin-intake front end for the vending datapath. Latches a cost at transaction start, then accepts nickels, dimes and quarters one per handshake, accumulating the amount paid in nickel units until it covers the cost. Rejects any coin that cannot be accepted, and aborts on an inactivity timeout. Its `paid` and `cost_q` outputs feed the downstream change-dispensing logic.

## Interface
- `TIMEOUT_CYCLES`, default 16: the number of idle COLLECT cycles with no accepted coin before the transaction aborts. Legal range is 1..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start`  in  1  begins a transaction; honoured only in IDLE.
- `cost`  in  4  price in nickels, 0..15; sampled only on an accepted `start`.
- `coin_valid`  in  1  a coin is presented this cycle.
- `coin_type`  in  2  coin code: 01 = nickel (value 1), 10 = dime (value 2), 11 = quarter (value 5), 00 = slug/invalid.
- `coin_accept`  out  1  one-cycle pulse: the coin was kept.
- `coin_reject`  out  1  one-cycle pulse: the coin was returned.
- `cost_q`  out  4  the latched cost.
- `paid`  out  4  accumulated amount in nickels, 0..15.
- `nickels`, `dimes`, `quarters`  out  2 each  per-type tally of accepted coins, 0..3.
- `busy`  out  1  high in COLLECT.
- `done`  out  1  one-cycle pulse: `paid` >= `cost_q`.
- `timeout`  out  1  one-cycle pulse: transaction aborted.

## Operation
- The state machine has four states: IDLE, COLLECT, DONE, ABORT. DONE and ABORT each last exactly one cycle, then return to IDLE.
- **IDLE:**
  - On `start`: latch `cost` into `cost_q`, clear `paid` and all tallies, clear the timeout counter.
  - Next state is DONE if `cost` == 0, otherwise COLLECT.
  - Without `start`, `paid`, tallies and `cost_q` hold their last values so downstream logic can read them.
- **COLLECT**, when `coin_valid` is high:
  - Value v: nickel = 1, dime = 2, quarter = 5.
  - **Accept** when all hold: `coin_type` != 00, the tally for that type < 3, and `paid` + v <= 15. The sum is computed 5 bits wide.
  - On accept: `paid` <= `paid` + v, that tally increments by 1, the timeout counter clears, and `coin_accept` pulses.
  - If the new `paid` >= `cost_q`, next state is DONE.
  - **Reject** otherwise: `coin_reject` pulses and no other state changes.
- **COLLECT**, when `coin_valid` is low:
  - The timeout counter increments by 1.
  - When the counter equals `TIMEOUT_CYCLES`, next state is ABORT.
  - A cycle with an accepted coin never times out.
  - A cycle with a rejected coin still counts as idle and increments the counter.
- **Outside COLLECT:** any `coin_valid` produces `coin_reject`, including the cycle in which `start` is accepted.
- **DONE:** `done` is high. `paid` and tallies hold; the downstream change is `paid` - `cost_q`.
- **ABORT:** `timeout` is high. `paid` and tallies hold so the refund logic can read them.
- **Ignored `start`:** a `start` outside IDLE has no effect.
- **Reset:** a reset asserted mid-transaction abandons it with no `done` or `timeout` pulse.

## Timing
- **Reset values:** state IDLE; `paid`, `cost_q`, tallies and timeout counter all 0; `coin_accept`, `coin_reject`, `done`, `timeout` and `busy` all 0.
- **Output registration:**
  - `coin_accept` and `coin_reject` are registered: they are high in the cycle after the one in which `coin_valid` is sampled.
  - `paid` and the tallies update on that same edge.
  - Exactly one of `coin_accept` or `coin_reject` pulses per `coin_valid` cycle.
  - Back-to-back `coin_valid` cycles are each handled independently.
- **Decoded outputs:** `done`, `timeout` and `busy` are decoded from the state register.
  - The accept that completes payment and `done` are high in the same cycle.
- **Start latency:** `start` in cycle t gives `busy` in cycle t+1.
  - With `cost` == 0, `done` is high in cycle t+1 instead.
- **Timeout latency:** with no coins presented, `timeout` is high `TIMEOUT_CYCLES` + 1 cycles after COLLECT is entered.
- **Reset priority:** `rst_n` low overrides every other input in that cycle.

## Test plan
- **Exact payment:** reset, `start` with `cost` = 7, then present a quarter and then a dime on consecutive cycles. Expect two `coin_accept` pulses, `paid` = 7, `quarters` = 1, `dimes` = 1, and `done` high coincident with the second accept.
- **Overpayment and tally saturation:** `cost` = 14, then present 3 quarters followed by a 4th quarter.
  - The third quarter is accepted: `paid` = 15, `done` pulses.
  - The fourth quarter is presented in DONE/IDLE and gets `coin_reject`.
- **Rejection rules:**
  - `cost` = 15: present a slug (`coin_type` = 00), then a nickel at `paid` = 12 with 3 nickels already tallied. Both get `coin_reject`; `paid` is unchanged.
  - A dime at `paid` = 14 gets `coin_reject`, because 14 + 2 > 15.
- **Timeout:** `TIMEOUT_CYCLES` = 4, `cost` = 5, one nickel, then no coins. Expect `timeout` high 5 cycles after the accept cycle, `paid` still 1, then return to IDLE.
- **Zero cost and ignored start:** `start` with `cost` = 0 gives `done` the next cycle. A `start` pulsed while in COLLECT leaves `cost_q` and `paid` unchanged.
- **Reset mid-transaction:** at `paid` = 3 in COLLECT, drive `rst_n` low for one cycle. All outputs go to 0 and the state is IDLE, with no `done` or `timeout` pulse.

Source files
------------

// File: rtl/coin_collector.sv
// coin_collector
//   Coin-intake front end for the vending datapath. A transaction latches a
//   price (in nickels), then accepts nickels, dimes and quarters one per
//   coin_valid cycle until the amount paid covers the price. Coins that cannot
//   be kept are returned, and a transaction with too many idle cycles aborts.
//
// Ports
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   start        begin a transaction (honoured in IDLE only)
//   cost[3:0]    price in nickels, sampled with an accepted start
//   coin_valid   a coin is presented this cycle
//   coin_type    01 nickel, 10 dime, 11 quarter, 00 slug
//   coin_accept  registered pulse: presented coin was kept
//   coin_reject  registered pulse: presented coin was returned
//   cost_q[3:0]  latched price
//   paid[3:0]    accumulated payment in nickels
//   nickels, dimes, quarters  per-type tallies of kept coins (0..3)
//   busy         collecting coins
//   done         one-cycle pulse, payment covers the price
//   timeout      one-cycle pulse, transaction aborted on inactivity
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; paid/tallies/cost_q hold for downstream
// COLLECT | accepting coins, idle timer running
// DONE    | one cycle, paid >= cost_q; change is paid - cost_q
// ABORT   | one cycle, inactivity timeout; paid/tallies hold for refund

module coin_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cost,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic [3:0] cost_q,
  output logic [3:0] paid,
  output logic [1:0] nickels,
  output logic [1:0] dimes,
  output logic [1:0] quarters,
  output logic       busy,
  output logic       done,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2,
    S_ABORT   = 2'd3
  } state_t;

  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES);

  state_t     state;
  // Idle-cycle down-counter: reaching zero means TIMEOUT_CYCLES idle cycles
  // have already elapsed, so the next non-accepting cycle aborts.
  logic [7:0] tmr;

  logic [2:0] coin_val;
  logic [1:0] coin_tally;
  logic [4:0] paid_sum;
  logic       coin_ok;
  logic       accept_now;

  always_comb begin
    coin_val   = 3'd0;
    coin_tally = 2'd3;
    case (coin_type)
      2'b01: begin coin_val = 3'd1; coin_tally = nickels;  end
      2'b10: begin coin_val = 3'd2; coin_tally = dimes;    end
      2'b11: begin coin_val = 3'd5; coin_tally = quarters; end
      default: begin coin_val = 3'd0; coin_tally = 2'd3; end
    endcase
    // 5-bit sum so an overflow past 15 is visible rather than wrapping.
    paid_sum   = {1'b0, paid} + {2'b00, coin_val};
    coin_ok    = (coin_type != 2'b00) && (coin_tally != 2'd3) && (paid_sum <= 5'd15);
    accept_now = (state == S_COLLECT) && coin_valid && coin_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tmr         <= 8'd0;
      cost_q      <= 4'd0;
      paid        <= 4'd0;
      nickels     <= 2'd0;
      dimes       <= 2'd0;
      quarters    <= 2'd0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      // Every presented coin gets exactly one verdict, whatever the state.
      coin_accept <= accept_now;
      coin_reject <= coin_valid && !accept_now;

      case (state)
        S_IDLE: begin
          if (start) begin
            cost_q   <= cost;
            paid     <= 4'd0;
            nickels  <= 2'd0;
            dimes    <= 2'd0;
            quarters <= 2'd0;
            tmr      <= TMR_LOAD;
            state    <= (cost == 4'd0) ? S_DONE : S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (accept_now) begin
            paid <= paid_sum[3:0];
            case (coin_type)
              2'b01:   nickels  <= nickels + 2'd1;
              2'b10:   dimes    <= dimes + 2'd1;
              default: quarters <= quarters + 2'd1;
            endcase
            tmr <= TMR_LOAD;
            if (paid_sum >= {1'b0, cost_q}) begin
              state <= S_DONE;
            end
          end else if (tmr == 8'd0) begin
            // Rejected coins count as idle cycles too.
            state <= S_ABORT;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        S_DONE:  state <= S_IDLE;
        S_ABORT: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state == S_COLLECT);
  assign done    = (state == S_DONE);
  assign timeout = (state == S_ABORT);

endmodule
